// File: rtl/mux_unstriping_n.sv
// mux_unstriping_n: rebuilds one ordered stream from LANES round-robin striped lanes.
// Latency: a word pushed at edge E into the selected empty lane FIFO is on data_out after E+1.
// Backpressure: none upstream; a full lane FIFO that is not popped drops the word and flags overflow.

module mux_unstriping_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_dat_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              push_ok;
  logic              pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o    = (wr_q == rd_q);
  assign head_dat_o = mem_q[rd_q[AW-1:0]];
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PTR_ONE;
      if (pop_ok)  rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

module mux_unstriping_n #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                       clk_2f,
  input  logic                                       reset_L,
  input  logic [LANES*DATA_W-1:0]                    data_in,
  input  logic [LANES-1:0]                           valid_in,
  input  logic                                       resync,
  output logic [DATA_W-1:0]                          data_out,
  output logic                                       valid_out,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_out,
  output logic [LANES-1:0]                           overflow
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  logic [LANES-1:0]  push;
  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  full;
  logic [LANES-1:0]  empty;
  logic [DATA_W-1:0] head [LANES];

  logic [LW-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [LANES-1:0]  ovf_q, ovf_d;

  assign push = resync ? '0 : valid_in;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mux_unstriping_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk_2f),
      .rst_n      (reset_L),
      .flush_i    (resync),
      .push_i     (push[g]),
      .push_dat_i (data_in[g*DATA_W +: DATA_W]),
      .pop_i      (pop[g]),
      .head_dat_o (head[g]),
      .full_o     (full[g]),
      .empty_o    (empty[g])
    );
  end

  // The pointer waits on an empty lane rather than skipping it, so order survives skew.
  always_comb begin
    pop     = '0;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lane_d  = lane_q;
    ovf_d   = ovf_q;
    if (resync) begin
      sel_d = '0;
    end else begin
      if (!empty[sel_q]) begin
        pop[sel_q] = 1'b1;
        data_d     = head[sel_q];
        valid_d    = 1'b1;
        lane_d     = sel_q;
        sel_d      = (sel_q == LAST_LANE) ? '0 : sel_q + LANE_ONE;
      end
      ovf_d = ovf_q | (valid_in & full & ~pop);
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      ovf_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_mux_unstriping_n.sv
// Bench for mux_unstriping_n: a 2-lane and a 4-lane instance against a queue-based model,
// plus literal expectations for the directed scenarios.
module tb_mux_unstriping_n;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk_2f = 1'b0;
  logic reset_L = 1'b1;
  always #5 clk_2f = ~clk_2f;

  logic [2*DW-1:0] din2;
  logic [1:0]      vin2;
  logic            rsy2;
  logic [DW-1:0]   dout2;
  logic            vout2;
  logic            lane2;
  logic [1:0]      ovf2;

  logic [4*DW-1:0] din4;
  logic [3:0]      vin4;
  logic            rsy4;
  logic [DW-1:0]   dout4;
  logic            vout4;
  logic [1:0]      lane4;
  logic [3:0]      ovf4;

  mux_unstriping_n #(.DATA_W(DW), .LANES(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk_2f(clk_2f), .reset_L(reset_L), .data_in(din2), .valid_in(vin2), .resync(rsy2),
    .data_out(dout2), .valid_out(vout2), .lane_out(lane2), .overflow(ovf2));

  mux_unstriping_n #(.DATA_W(DW), .LANES(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk_2f(clk_2f), .reset_L(reset_L), .data_in(din4), .valid_in(vin4), .resync(rsy4),
    .data_out(dout4), .valid_out(vout4), .lane_out(lane4), .overflow(ovf4));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Model: per-lane queues, a lane pointer, and the output registers.
  logic [31:0] mq [2][4][$];
  int          msel [2];
  logic        mvalid [2];
  logic [31:0] mdata [2];
  int          mlane [2];
  logic [3:0]  movf [2];
  int          nl [2] = '{2, 4};
  logic [3:0]  m_v;
  logic        m_r;
  logic [31:0] m_w;

  always @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) mq[k][i].delete();
        msel[k] = 0; mvalid[k] = 1'b0; mdata[k] = '0; mlane[k] = 0; movf[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin m_v = {2'b00, vin2}; m_r = rsy2; end
        else        begin m_v = vin4;          m_r = rsy4; end
        if (m_r) begin
          for (int i = 0; i < 4; i++) mq[k][i].delete();
          msel[k] = 0;
          mvalid[k] = 1'b0;
        end else begin
          if (mq[k][msel[k]].size() > 0) begin
            mdata[k] = mq[k][msel[k]].pop_front();
            mvalid[k] = 1'b1;
            mlane[k] = msel[k];
            msel[k] = (msel[k] + 1) % nl[k];
          end else begin
            mvalid[k] = 1'b0;
          end
          for (int i = 0; i < nl[k]; i++) begin
            if (m_v[i]) begin
              if (k == 0) m_w = din2[i*DW +: DW];
              else        m_w = din4[i*DW +: DW];
              if (mq[k][i].size() < DEPTH) mq[k][i].push_back(m_w);
              else movf[k][i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(posedge clk_2f) cyc <= cyc + 1;

  logic [31:0] ld [2][$];
  int          ll [2][$];
  int          lc [2][$];

  always @(negedge clk_2f) begin
    check("cmp2_valid", 32'(vout2), 32'(mvalid[0]));
    check("cmp2_data",  dout2, mdata[0]);
    check("cmp2_lane",  32'(lane2), 32'(mlane[0]));
    check("cmp2_ovf",   32'(ovf2), 32'(movf[0][1:0]));
    check("cmp4_valid", 32'(vout4), 32'(mvalid[1]));
    check("cmp4_data",  dout4, mdata[1]);
    check("cmp4_lane",  32'(lane4), 32'(mlane[1]));
    check("cmp4_ovf",   32'(ovf4), 32'(movf[1]));
    if (vout2) begin ld[0].push_back(dout2); ll[0].push_back(int'(lane2)); lc[0].push_back(cyc); end
    if (vout4) begin ld[1].push_back(dout4); ll[1].push_back(int'(lane4)); lc[1].push_back(cyc); end
  end

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin ld[k].delete(); ll[k].delete(); lc[k].delete(); end
  endtask

  task automatic chk_ent(input string n, input int k, input int i, input logic [31:0] d, input int l);
    logic [31:0] ad;
    int al;
    ad = (i < ld[k].size()) ? ld[k][i] : 32'hDEAD_BEEF;
    al = (i < ll[k].size()) ? ll[k][i] : -1;
    check({n, "_dat"}, ad, d);
    check({n, "_lane"}, al, l);
  endtask

  task automatic chk_gap(input string n, input int k, input int i, input int off);
    int a;
    a = (i < lc[k].size()) ? lc[k][i] - lc[k][0] : -1;
    check(n, a, off);
  endtask

  task automatic idle(input int n);
    vin2 = '0; rsy2 = 1'b0; vin4 = '0; rsy4 = 1'b0;
    repeat (n) @(negedge clk_2f);
  endtask

  task automatic c2(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b, input logic r);
    vin2 = v; din2 = {b, a}; rsy2 = r;
    @(negedge clk_2f);
    vin2 = '0; rsy2 = 1'b0;
  endtask

  task automatic c4(input logic [3:0] v, input logic [31:0] w0, input logic [31:0] w1,
                    input logic [31:0] w2, input logic [31:0] w3);
    vin4 = v; din4 = {w3, w2, w1, w0};
    @(negedge clk_2f);
    vin4 = '0;
  endtask

  logic [31:0] a_w [8];
  logic [31:0] b_w [8];
  logic [31:0] exp_seq [10];
  int          exp_ln [10];

  initial begin
    for (int i = 0; i < 8; i++) begin
      a_w[i] = 32'hA000_0000 + 32'(i);
      b_w[i] = 32'hB000_0000 + 32'(i);
    end
    vin2 = '0; din2 = '0; rsy2 = 1'b0;
    vin4 = '0; din4 = '0; rsy4 = 1'b0;
    #1 reset_L = 1'b0;
    #1;
    check("rst_valid2", 32'(vout2), 0);
    check("rst_data2",  dout2, 0);
    check("rst_lane4",  32'(lane4), 0);
    check("rst_ovf4",   32'(ovf4), 0);
    @(negedge clk_2f); @(negedge clk_2f);
    reset_L = 1'b1;
    idle(2);

    // Interleaved lanes come out A0,B0,A1,B1 back to back.
    clear_logs();
    c2(2'b11, a_w[0], b_w[0], 1'b0);
    c2(2'b11, a_w[1], b_w[1], 1'b0);
    idle(6);
    check("t1_count", ld[0].size(), 4);
    chk_ent("t1_e0", 0, 0, a_w[0], 0);
    chk_ent("t1_e1", 0, 1, b_w[0], 1);
    chk_ent("t1_e2", 0, 2, a_w[1], 0);
    chk_ent("t1_e3", 0, 3, b_w[1], 1);
    chk_gap("t1_gap3", 0, 3, 3);

    // Lane1 three cycles late: two idle output cycles between A0 and B0.
    clear_logs();
    c2(2'b01, a_w[2], 32'h0, 1'b0);
    idle(2);
    c2(2'b10, 32'h0, b_w[2], 1'b0);
    idle(6);
    check("t2_count", ld[0].size(), 2);
    chk_ent("t2_e0", 0, 0, a_w[2], 0);
    chk_ent("t2_e1", 0, 1, b_w[2], 1);
    chk_gap("t2_gap", 0, 1, 3);

    // Six words on lane0 with lane1 silent: A5 dropped; later a push into a full-but-popped FIFO lands.
    clear_logs();
    for (int j = 0; j < 6; j++) c2(2'b01, a_w[j], 32'h0, 1'b0);
    check("t3_ovf_set", 32'(ovf2), 32'h1);
    check("t3_count_stall", ld[0].size(), 1);
    c2(2'b10, 32'h0, b_w[0], 1'b0);
    c2(2'b10, 32'h0, b_w[1], 1'b0);
    c2(2'b11, a_w[6], b_w[2], 1'b0);
    c2(2'b10, 32'h0, b_w[3], 1'b0);
    c2(2'b10, 32'h0, b_w[4], 1'b0);
    idle(10);
    exp_seq = '{b_w[0], a_w[1], b_w[1], a_w[2], b_w[2], a_w[3], b_w[3], a_w[4], b_w[4], a_w[6]};
    exp_ln  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    check("t3_count", ld[0].size(), 11);
    chk_ent("t3_first", 0, 0, a_w[0], 0);
    for (int j = 0; j < 10; j++) chk_ent($sformatf("t3_e%0d", j + 1), 0, j + 1, exp_seq[j], exp_ln[j]);
    check("t3_ovf_sticky", 32'(ovf2), 32'h1);

    // Resync with words buffered: inputs on that edge discarded, restart at lane 0.
    clear_logs();
    c2(2'b11, 32'hC000_0000, 32'hD000_0000, 1'b0);
    c2(2'b11, 32'hC000_0001, 32'hD000_0001, 1'b0);
    c2(2'b11, 32'hC000_0002, 32'hD000_0002, 1'b0);
    c2(2'b11, 32'hC000_0003, 32'hD000_0003, 1'b1);
    check("t5_valid_low", 32'(vout2), 0);
    check("t5_data_hold", dout2, 32'hC000_0000);
    check("t5_lane_hold", 32'(lane2), 0);
    c2(2'b10, 32'h0, 32'hE000_0001, 1'b0);
    c2(2'b01, 32'hE000_0000, 32'h0, 1'b0);
    idle(4);
    check("t5_count", ld[0].size(), 4);
    chk_ent("t5_e0", 0, 0, 32'hD000_0000, 1);
    chk_ent("t5_e1", 0, 1, 32'hC000_0000, 0);
    chk_ent("t5_e2", 0, 2, 32'hE000_0000, 0);
    chk_ent("t5_e3", 0, 3, 32'hE000_0001, 1);
    check("t5_ovf_hold", 32'(ovf2), 32'h1);

    // Four lanes, 20 rounds staggered one lane per cycle: a gap-free ordered stream.
    clear_logs();
    for (int t = 0; t < 80; t++) begin
      vin4 = 4'(1 << (t % 4));
      din4 = '0;
      din4[(t % 4)*DW +: DW] = 32'(256 * (t % 4) + t / 4);
      @(negedge clk_2f);
      vin4 = '0;
    end
    idle(4);
    check("t4_count", ld[1].size(), 80);
    for (int t = 0; t < 80; t++) begin
      chk_ent("t4_e", 1, t, 32'(256 * (t % 4) + t / 4), t % 4);
      chk_gap("t4_gap", 1, t, t);
    end
    check("t4_ovf", 32'(ovf4), 0);

    // Asynchronous reset mid-stream, then restart from lane 0.
    c4(4'b1111, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    c4(4'b1111, 32'hF4, 32'hF5, 32'hF6, 32'hF7);
    #3 reset_L = 1'b0;
    #1;
    check("t6_valid4", 32'(vout4), 0);
    check("t6_data4",  dout4, 0);
    check("t6_lane4",  32'(lane4), 0);
    check("t6_ovf2",   32'(ovf2), 0);
    @(negedge clk_2f); @(negedge clk_2f);
    reset_L = 1'b1;
    clear_logs();
    c4(4'b0010, 32'h0, 32'h5151, 32'h0, 32'h0);
    c4(4'b0001, 32'h5050, 32'h0, 32'h0, 32'h0);
    idle(4);
    check("t6_count", ld[1].size(), 2);
    chk_ent("t6_e0", 1, 0, 32'h5050, 0);
    chk_ent("t6_e1", 1, 1, 32'h5151, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
